// File: rtl/particle_pkg.sv
// Shared types and helpers for the particle RAM readers and the physics pipeline.
// Even RAM addresses hold position words, odd addresses hold velocity words.
package particle_pkg;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [31:0] reserved;
   } particle_word_t;

   localparam int POS_OFFSET = 0;
   localparam int VEL_OFFSET = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_DONE = 2'd2
   } reader_state_t;

   function automatic int max_particles(input int addr_width);
      return 1 << (addr_width - 1);
   endfunction

endpackage

// File: rtl/particle_reader_sync_fifo.sv
// Synchronous single-clock FIFO with occupancy count; DEPTH must be a power of two.
// A push while full is dropped and flagged by the assertion below.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assert property (@(posedge clk_in) disable iff (!rst_n_in) !(push && full));

endmodule

// File: rtl/particle_reader.sv
// Sweeps particle RAM addresses 0..2N-1 and streams {position, velocity} records.
// Reads are credit-limited so every returning word is guaranteed a FIFO slot.
module particle_reader
   import particle_pkg::*;
#(
   parameter int ADDR_WIDTH   = 11,
   parameter int RAM_WIDTH    = 64,
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  start_in,
   input  logic [15:0]           particle_count_in,
   output logic [ADDR_WIDTH-1:0] ram_addr_out,
   output logic                  ram_en_out,
   input  logic [RAM_WIDTH-1:0]  ram_data_in,
   output logic [RAM_WIDTH-1:0]  pos_out,
   output logic [RAM_WIDTH-1:0]  vel_out,
   output logic [15:0]           index_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic                  busy_out,
   output logic                  done_out,
   output reader_state_t         state_dbg_out
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam int FW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [16:0] MAX_CNT = 17'(max_particles(ADDR_WIDTH));

   reader_state_t          state;
   logic [CW-1:0]          issue_addr;
   logic [CW-1:0]          last_addr;
   logic [15:0]            last_index;
   logic [FW-1:0]          outstanding;
   logic [READ_LATENCY-1:0] lat_sr;
   logic                   expect_vel;
   logic [RAM_WIDTH-1:0]   pos_hold;
   logic [16:0]            clamped;

   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [RAM_WIDTH-1:0]   fifo_head;
   logic [FW-1:0]          fifo_count;

   logic                   handshake;
   logic                   can_load;
   logic                   pop_pos;
   logic                   pop_vel;
   logic                   issue_ok;
   logic                   issue_fire;
   logic                   start_issue;
   logic                   issue_any;

   assign state_dbg_out = state;
   assign clamped = ({1'b0, particle_count_in} > MAX_CNT) ? MAX_CNT : {1'b0, particle_count_in};

   // Stream contract: a record transfers on valid_out && ready_in; while valid_out is
   // high and ready_in low, pos/vel/index hold; a new record may load on a transfer cycle.
   assign handshake = valid_out && ready_in;
   assign can_load  = !valid_out || ready_in;
   assign pop_pos   = !expect_vel && !fifo_empty;
   assign pop_vel   = expect_vel && !fifo_empty && can_load;
   assign fifo_pop  = pop_pos || pop_vel;
   assign fifo_push = lat_sr[READ_LATENCY-1];

   // A word leaving the FIFO this cycle hands its credit straight to the next read.
   assign issue_ok    = ({1'b0, outstanding} + {1'b0, fifo_count}) <
                        ((FW+1)'(FIFO_DEPTH) + (FW+1)'(fifo_pop));
   assign issue_fire  = (state == ST_READ) && (issue_addr <= last_addr) && issue_ok;
   assign start_issue = (state == ST_IDLE) && start_in && (clamped != '0);
   assign issue_any   = issue_fire || start_issue;

   sync_fifo #(
      .WIDTH (RAM_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .push      (fifo_push),
      .push_data (ram_data_in),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state        <= ST_IDLE;
         ram_addr_out <= '0;
         ram_en_out   <= 1'b0;
         pos_out      <= '0;
         vel_out      <= '0;
         index_out    <= '0;
         valid_out    <= 1'b0;
         busy_out     <= 1'b0;
         done_out     <= 1'b0;
         issue_addr   <= '0;
         last_addr    <= '0;
         last_index   <= '0;
         outstanding  <= '0;
         lat_sr       <= '0;
         expect_vel   <= 1'b0;
         pos_hold     <= '0;
      end else begin
         ram_en_out  <= 1'b0;
         done_out    <= 1'b0;
         lat_sr      <= READ_LATENCY'({lat_sr, ram_en_out});
         outstanding <= outstanding + FW'(issue_any) - FW'(fifo_push);

         if (pop_pos) begin
            pos_hold   <= fifo_head;
            expect_vel <= 1'b1;
         end
         if (pop_vel) begin
            expect_vel <= 1'b0;
            pos_out    <= pos_hold;
            vel_out    <= fifo_head;
            valid_out  <= 1'b1;
         end else if (handshake) begin
            valid_out  <= 1'b0;
         end
         if (handshake) index_out <= index_out + 16'd1;

         case (state)
            ST_IDLE: begin
               if (start_in) begin
                  last_addr  <= CW'({clamped, 1'b0} - 18'd1);
                  last_index <= 16'(clamped - 17'd1);
                  index_out  <= '0;
                  if (clamped == '0) begin
                     state    <= ST_DONE;
                     done_out <= 1'b1;
                  end else begin
                     state        <= ST_READ;
                     busy_out     <= 1'b1;
                     ram_en_out   <= 1'b1;
                     ram_addr_out <= '0;
                     issue_addr   <= CW'(1);
                  end
               end
            end
            ST_READ: begin
               if (issue_fire) begin
                  ram_en_out   <= 1'b1;
                  ram_addr_out <= issue_addr[ADDR_WIDTH-1:0];
                  issue_addr   <= issue_addr + CW'(1);
               end
               if (handshake && (index_out == last_index)) begin
                  state    <= ST_DONE;
                  busy_out <= 1'b0;
                  done_out <= 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assert property (@(posedge clk_in) disable iff (!rst_n_in) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_particle_reader.sv
// Directed bench for particle_reader: two instances (latency 2/depth 4 and latency 3/depth 8)
// share stimulus; each has its own RAM model, address checker and record scoreboard.
module tb_particle_reader;
   import particle_pkg::*;

   localparam int AW = 11;
   localparam int RW = 64;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        start_in = 1'b0;
   logic        ready_in = 1'b0;
   logic [15:0] count_in = 16'd0;

   logic [AW-1:0] ram_addr [2];
   logic          ram_en   [2];
   logic [RW-1:0] pos      [2];
   logic [RW-1:0] vel      [2];
   logic [15:0]   index    [2];
   logic          valid    [2];
   logic          busy     [2];
   logic          done     [2];
   reader_state_t st       [2];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic tb_load = 1'b0;
   int   tb_cnt = 0;
   logic gap_chk = 1'b0;

   int hs_cnt   [2];
   int rd_cnt   [2];
   int done_cnt [2];
   int exp_left [2];
   int last_rd  [2];

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [RW-1:0] ram_word(input logic [AW-1:0] a);
      particle_word_t w;
      logic [15:0] i;
      i = 16'(a >> 1);
      if (int'(a[0]) == POS_OFFSET) begin
         w.x = i;
         w.y = i + 16'd100;
         w.reserved = 32'h0;
      end else begin
         w.x = i + 16'h0200;
         w.y = i + 16'h0300;
         w.reserved = 32'hBEEF_0000 + {16'h0, i};
      end
      return w;
   endfunction

   function automatic logic [191:0] rec_model(input int i);
      return {48'h0, 16'(i), ram_word(AW'(2*i + POS_OFFSET)), ram_word(AW'(2*i + VEL_OFFSET))};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int LAT = (g == 0) ? 2 : 3;
      localparam int DEP = (g == 0) ? 4 : 8;

      logic [AW-1:0]  pipe [LAT];
      logic [RW-1:0]  rdata;
      logic [191:0]   exp_q [$];
      logic [191:0]   prev_rec;
      logic           prev_stall = 1'b0;
      int             exp_addr = 0;
      int             last_hs = 0;

      particle_reader #(
         .ADDR_WIDTH   (AW),
         .RAM_WIDTH    (RW),
         .READ_LATENCY (LAT),
         .FIFO_DEPTH   (DEP)
      ) dut (
         .clk_in            (clk_in),
         .rst_n_in          (rst_n_in),
         .start_in          (start_in),
         .particle_count_in (count_in),
         .ram_addr_out      (ram_addr[g]),
         .ram_en_out        (ram_en[g]),
         .ram_data_in       (rdata),
         .pos_out           (pos[g]),
         .vel_out           (vel[g]),
         .index_out         (index[g]),
         .valid_out         (valid[g]),
         .ready_in          (ready_in),
         .busy_out          (busy[g]),
         .done_out          (done[g]),
         .state_dbg_out     (st[g])
      );

      always @(posedge clk_in) begin
         pipe[0] <= ram_addr[g];
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign rdata = ram_word(pipe[LAT-1]);

      always @(negedge clk_in) begin
         logic [191:0] cur;
         logic [191:0] exp;
         cur = {48'h0, index[g], pos[g], vel[g]};
         if (!rst_n_in) begin
            exp_q.delete();
            prev_stall = 1'b0;
         end else begin
            if (tb_load) begin
               exp_q.delete();
               exp_addr = 0;
               rd_cnt[g] = 0;
               hs_cnt[g] = 0;
               done_cnt[g] = 0;
               for (int i = 0; i < tb_cnt; i++) exp_q.push_back(rec_model(i));
            end
            if (ram_en[g]) begin
               check($sformatf("addr_l%0d", g), 192'(ram_addr[g]), 192'(exp_addr));
               last_rd[g] = int'(ram_addr[g]);
               exp_addr++;
               rd_cnt[g]++;
            end
            if (prev_stall) check($sformatf("hold_l%0d", g), cur, prev_rec);
            if (valid[g] && ready_in) begin
               if (exp_q.size() > 0) exp = exp_q.pop_front();
               else exp = '1;
               check($sformatf("rec_l%0d", g), cur, exp);
               if (gap_chk && hs_cnt[g] > 0) check($sformatf("gap_l%0d", g), 192'(cyc - last_hs), 192'(2));
               last_hs = cyc;
               hs_cnt[g]++;
            end
            if (done[g]) done_cnt[g]++;
            prev_stall = valid[g] && !ready_in;
            prev_rec = cur;
         end
         exp_left[g] = exp_q.size();
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic start_sweep(input int cnt, input logic load);
      tick();
      start_in = 1'b1;
      count_in = 16'(cnt);
      tb_load  = load;
      tb_cnt   = (cnt > 1024) ? 1024 : cnt;
      tick();
      start_in = 1'b0;
      tb_load  = 1'b0;
      count_in = 16'($urandom_range(0, 65535));
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!busy[0] && !busy[1] && !done[0] && !done[1]) break;
      end
      check(tag, 192'({busy[0], busy[1]}), 192'(0));
   endtask

   task automatic check_zero(input string tag);
      for (int g = 0; g < 2; g++)
         check($sformatf("%s_l%0d", tag, g),
               192'({st[g], valid[g], busy[g], done[g], ram_en[g], ram_addr[g], index[g], pos[g], vel[g]}),
               192'(0));
   endtask

   task automatic check_lanes(input string tag, input int recs);
      for (int g = 0; g < 2; g++) begin
         check($sformatf("%s_hs_l%0d", tag, g), 192'(hs_cnt[g]), 192'(recs));
         check($sformatf("%s_rd_l%0d", tag, g), 192'(rd_cnt[g]), 192'(2 * recs));
         check($sformatf("%s_done_l%0d", tag, g), 192'(done_cnt[g]), 192'(1));
         check($sformatf("%s_left_l%0d", tag, g), 192'(exp_left[g]), 192'(0));
      end
   endtask

   initial begin
      int lat0, lat1, snap0, snap1;
      logic [RW-1:0] p0, v0;

      rst_n_in = 1'b0;
      repeat (3) tick();
      check_zero("reset");
      rst_n_in = 1'b1;
      ready_in = 1'b1;

      // count=4, ready held high
      gap_chk = 1'b1;
      start_sweep(4, 1'b1);
      lat0 = 0;
      lat1 = 0;
      p0 = '0;
      v0 = '0;
      for (int k = 1; k <= 20; k++) begin
         if (valid[0] && lat0 == 0) begin
            lat0 = k;
            p0 = pos[0];
            v0 = vel[0];
         end
         if (valid[1] && lat1 == 0) lat1 = k;
         if (lat0 != 0 && lat1 != 0) break;
         tick();
      end
      check("lat_l0", 192'(lat0 >= 1 && lat0 <= 2 + 4), 192'(1));
      check("lat_l1", 192'(lat1 >= 1 && lat1 <= 3 + 4), 192'(1));
      check("rec0_pos", 192'(p0), 192'(64'h0000_0064_0000_0000));
      check("rec0_vel", 192'(v0), 192'(64'h0200_0300_BEEF_0000));
      wait_idle("t1_idle", 100);
      gap_chk = 1'b0;
      check_lanes("t1", 4);
      repeat (3) tick();
      check("t1_busy_after", 192'({busy[0], busy[1], done[0], done[1]}), 192'(0));

      // count=0: done next cycle, no reads, no records
      start_sweep(0, 1'b1);
      check("t2_pulse", 192'({done[0], done[1], busy[0], busy[1], valid[0], valid[1]}), 192'(6'b110000));
      tick();
      check("t2_pulse_end", 192'({done[0], done[1]}), 192'(0));
      repeat (5) tick();
      check_lanes("t2", 0);

      // count=8 with random ready then a long stall
      start_sweep(8, 1'b1);
      for (int k = 0; k < 10; k++) begin
         ready_in = 1'($urandom_range(0, 1));
         tick();
      end
      ready_in = 1'b0;
      repeat (10) tick();
      snap0 = rd_cnt[0];
      snap1 = rd_cnt[1];
      repeat (10) tick();
      check("t3_stop_l0", 192'(rd_cnt[0]), 192'(snap0));
      check("t3_stop_l1", 192'(rd_cnt[1]), 192'(snap1));
      check("t3_en_low", 192'({ram_en[0], ram_en[1]}), 192'(0));
      check("t3_credit_l0", 192'(rd_cnt[0] - 2 * hs_cnt[0] <= 4 + 3), 192'(1));
      check("t3_credit_l1", 192'(rd_cnt[1] - 2 * hs_cnt[1] <= 8 + 3), 192'(1));
      ready_in = 1'b1;
      wait_idle("t3_idle", 200);
      check_lanes("t3", 8);

      // count=2000 clamps to 1024
      start_sweep(2000, 1'b1);
      wait_idle("t4_idle", 3000);
      check_lanes("t4", 1024);
      check("t4_last_l0", 192'(last_rd[0]), 192'(2047));
      check("t4_last_l1", 192'(last_rd[1]), 192'(2047));

      // reset in the middle of an 8-particle sweep, then a clean 2-particle sweep
      start_sweep(8, 1'b1);
      for (int k = 0; k < 100 && hs_cnt[0] < 3; k++) tick();
      check("t5_hs3", 192'(hs_cnt[0]), 192'(3));
      #2;
      rst_n_in = 1'b0;
      #1;
      check_zero("t5_rst");
      repeat (2) tick();
      rst_n_in = 1'b1;
      start_sweep(2, 1'b1);
      wait_idle("t5_idle", 100);
      check_lanes("t5", 2);

      // second start while busy is ignored
      start_sweep(4, 1'b1);
      repeat (2) tick();
      start_sweep(6, 1'b0);
      wait_idle("t6_idle", 100);
      check_lanes("t6", 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
